xpmwrap_tdpram_bwe: RTL and testbench

//  Common-clock true dual-port RAM with per-byte write enables and a configurable read latency.

---
 rtl/xpmwrap_pkg.sv | 45 ++++
 rtl/xpmwrap_rdpipe.sv | 50 +++++
 rtl/xpmwrap_tdpram_bwe.sv | 153 +++++++++++++++
 tb/tb_xpmwrap_tdpram_bwe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/xpmwrap_pkg.sv
// Shared types and helpers for the byte-write true dual-port RAM wrapper.
package xpmwrap_pkg;

  typedef enum logic {
    READ_FIRST = 1'b0,
    NO_CHANGE  = 1'b1
  } write_mode_e;

  // Upper bounds for the lane-merge helper; the top truncates to its own widths.
  localparam int unsigned MAX_DW     = 256;
  localparam int unsigned MAX_NB     = 64;
  localparam int unsigned LANE_IDX_W = 6;

  typedef struct packed {
    logic [MAX_DW-1:0] data;
    logic [MAX_NB-1:0] mask;
  } merge_t;

  function automatic int unsigned nb(input int unsigned data_width, input int unsigned byte_width);
    return data_width / byte_width;
  endfunction

  // Merge two same-address writes lane by lane; prio=1 lets port A win shared lanes.
  function automatic merge_t lane_merge(input logic [MAX_DW-1:0] dina,
                                        input logic [MAX_DW-1:0] dinb,
                                        input logic [MAX_NB-1:0] wea,
                                        input logic [MAX_NB-1:0] web,
                                        input logic              prio,
                                        input int unsigned       bw);
    merge_t                r;
    logic [LANE_IDX_W-1:0] l;
    r.data = '0;
    r.mask = wea | web;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      l = LANE_IDX_W'(i / bw);
      if (wea[l] && (prio || !web[l])) begin
        r.data[i] = dina[i];
      end else if (web[l]) begin
        r.data[i] = dinb[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xpmwrap_rdpipe.sv
// Extra read-latency stages behind the array output register; data advances only with valid.
module xpmwrap_rdpipe
  import xpmwrap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  if (STAGES == 0) begin : g_bypass
    logic unused_ports;
    assign unused_ports = clk ^ rstn;
    assign out_data     = in_data;
    assign out_valid    = in_valid;
  end else begin : g_pipe
    logic [DATA_WIDTH-1:0] data_q [STAGES];
    logic [STAGES-1:0]     valid_q;

    // Holding data on empty slots keeps dout stable between returned words.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        valid_q <= '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= in_data;
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

    assign out_data  = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
  end

endmodule

// File: rtl/xpmwrap_tdpram_bwe.sv
// Common-clock true dual-port RAM with byte-lane write enables, read-valid strobes and
// deterministic same-address collision handling with a saturating collision counter.
module xpmwrap_tdpram_bwe
  import xpmwrap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WRITE_MODE   = 0,
  parameter int unsigned PRIORITY_A   = 1,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  ena,
  input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]                 addra,
  input  logic [DATA_WIDTH-1:0]                 dina,
  output logic [DATA_WIDTH-1:0]                 douta,
  output logic                                  douta_valid,
  input  logic                                  enb,
  input  logic [nb(DATA_WIDTH, BYTE_WIDTH)-1:0] web,
  input  logic [ADDR_WIDTH-1:0]                 addrb,
  input  logic [DATA_WIDTH-1:0]                 dinb,
  output logic [DATA_WIDTH-1:0]                 doutb,
  output logic                                  doutb_valid,
  output logic                                  wr_collision,
  output logic                                  rw_hazard,
  output logic [CNT_WIDTH-1:0]                  coll_cnt
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NB     = nb(DATA_WIDTH, BYTE_WIDTH);
  localparam int unsigned STAGES = READ_LATENCY - 1;
  localparam write_mode_e WMODE  = (WRITE_MODE == 1) ? NO_CHANGE : READ_FIRST;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_lanes
    $error("xpmwrap_tdpram_bwe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("xpmwrap_tdpram_bwe: READ_LATENCY must be within 1..4");
  end
  if ((DATA_WIDTH > MAX_DW) || (NB > MAX_NB)) begin : g_too_wide
    $error("xpmwrap_tdpram_bwe: DATA_WIDTH or lane count exceeds lane_merge bounds");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  same_addr, wr_a, wr_b, both_wr, coll_now, hazard_now;
  logic                  take_a, take_b;
  merge_t                merged;
  logic                  unused_merge;
  logic [NB-1:0]         wmask_a, wmask_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  rvalid_a, rvalid_b;

  // Access classification and cross-port comparison.
  always_comb begin
    same_addr  = (addra == addrb);
    wr_a       = ena & (|wea);
    wr_b       = enb & (|web);
    both_wr    = wr_a & wr_b & same_addr;
    coll_now   = both_wr & (|(wea & web));
    hazard_now = ena & enb & same_addr & (wr_a ^ wr_b);
    take_a     = ena & (~(|wea) | (WMODE == READ_FIRST));
    take_b     = enb & (~(|web) | (WMODE == READ_FIRST));
  end

  always_comb begin
    merged = lane_merge(MAX_DW'(dina), MAX_DW'(dinb), MAX_NB'(wea), MAX_NB'(web),
                        (PRIORITY_A != 0), BYTE_WIDTH);
  end
  assign unused_merge = ^merged;

  // A same-address write pair is folded into one merged write carried on port A.
  always_comb begin
    wmask_a = '0;
    wmask_b = '0;
    wdata_a = dina;
    if (both_wr) begin
      wmask_a = NB'(merged.mask);
      wdata_a = DATA_WIDTH'(merged.data);
    end else begin
      if (ena) wmask_a = wea;
      if (enb) wmask_b = web;
    end
  end

  // Array write path; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wmask_a[i]) begin
          mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (wmask_b[i]) begin
          mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Array read register: samples the pre-write word, loads only on returning accesses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= take_a;
      rvalid_b <= take_b;
      if (take_a) rdata_a <= mem[addra];
      if (take_b) rdata_b <= mem[addrb];
    end
  end

  xpmwrap_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .STAGES(STAGES)) u_rdpipe_a (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (rdata_a),
    .in_valid (rvalid_a),
    .out_data (douta),
    .out_valid(douta_valid)
  );

  xpmwrap_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .STAGES(STAGES)) u_rdpipe_b (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  (rdata_b),
    .in_valid (rvalid_b),
    .out_data (doutb),
    .out_valid(doutb_valid)
  );

  // Registered flag pulses and saturating collision counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_collision <= 1'b0;
      rw_hazard    <= 1'b0;
      coll_cnt     <= '0;
    end else begin
      wr_collision <= coll_now;
      rw_hazard    <= hazard_now;
      if (coll_now && (coll_cnt != {CNT_WIDTH{1'b1}})) begin
        coll_cnt <= coll_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_xpmwrap_tdpram_bwe.sv
// Drives one stimulus stream into a latency/mode sweep of the RAM plus a port-B-priority,
// 2-bit-counter variant, and compares every instance against a lane-level memory model.
module tb_xpmwrap_tdpram_bwe;

  localparam int NI   = 9;
  localparam int HORZ = 4096;

  logic        clk = 1'b0;
  logic        rstn, ena, enb;
  logic [3:0]  wea, web;
  logic [5:0]  addra, addrb;
  logic [31:0] dina, dinb;

  logic [31:0] douta_g [NI];
  logic [31:0] doutb_g [NI];
  logic        va_g [NI];
  logic        vb_g [NI];
  logic        wc_g [NI];
  logic        rh_g [NI];
  logic [15:0] cnt_g [8];
  logic [1:0]  cnt8;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 8; k++) begin : g_sweep
    xpmwrap_tdpram_bwe #(
      .ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(k/2 + 1),
      .WRITE_MODE(k%2), .PRIORITY_A(1), .CNT_WIDTH(16)
    ) u_dut (
      .clk(clk), .rstn(rstn),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_g[k]), .douta_valid(va_g[k]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_g[k]), .doutb_valid(vb_g[k]),
      .wr_collision(wc_g[k]), .rw_hazard(rh_g[k]), .coll_cnt(cnt_g[k])
    );
  end

  xpmwrap_tdpram_bwe #(
    .ADDR_WIDTH(6), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2),
    .WRITE_MODE(0), .PRIORITY_A(0), .CNT_WIDTH(2)
  ) u_dut_pb (
    .clk(clk), .rstn(rstn),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_g[8]), .douta_valid(va_g[8]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_g[8]), .doutb_valid(vb_g[8]),
    .wr_collision(wc_g[8]), .rw_hazard(rh_g[8]), .coll_cnt(cnt8)
  );

  // Reference model: memory per priority flavour, return schedule indexed by edge number.
  logic [31:0] mm [2][64];
  bit          dva [NI][HORZ];
  bit          dvb [NI][HORZ];
  logic [31:0] dda [NI][HORZ];
  logic [31:0] ddb [NI][HORZ];
  logic [31:0] e_da [NI];
  logic [31:0] e_db [NI];
  bit          e_va [NI];
  bit          e_vb [NI];
  int          e_cnt [NI];
  bit          e_wc, e_rh;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic int rl_of(input int k);   return (k < 8) ? (k/2 + 1) : 2; endfunction
  function automatic int wm_of(input int k);   return (k < 8) ? (k % 2) : 0;   endfunction
  function automatic int pidx_of(input int k); return (k < 8) ? 0 : 1;         endfunction
  function automatic int cmax_of(input int k); return (k < 8) ? 65535 : 3;     endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d douta", k), douta_g[k], e_da[k]);
      chk($sformatf("i%0d doutb", k), doutb_g[k], e_db[k]);
      chk($sformatf("i%0d douta_valid", k), {31'b0, va_g[k]}, {31'b0, e_va[k]});
      chk($sformatf("i%0d doutb_valid", k), {31'b0, vb_g[k]}, {31'b0, e_vb[k]});
      chk($sformatf("i%0d wr_collision", k), {31'b0, wc_g[k]}, {31'b0, e_wc});
      chk($sformatf("i%0d rw_hazard", k), {31'b0, rh_g[k]}, {31'b0, e_rh});
      if (k < 8) chk($sformatf("i%0d coll_cnt", k), {16'b0, cnt_g[k]}, 32'(e_cnt[k]));
      else       chk("i8 coll_cnt", {30'b0, cnt8}, 32'(e_cnt[k]));
    end
  endtask

  task automatic step(input bit r,
                      input bit ea, input logic [3:0] wa, input logic [5:0] aa, input logic [31:0] da,
                      input bit eb, input logic [3:0] wb, input logic [5:0] ab, input logic [31:0] db);
    bit same, wra, wrb;
    @(negedge clk);
    rstn = r; ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    cyc++;
    if (!r) begin
      for (int k = 0; k < NI; k++) begin
        for (int c = cyc; c < cyc + 5; c++) begin
          dva[k][c] = 1'b0;
          dvb[k][c] = 1'b0;
        end
        e_da[k] = '0; e_db[k] = '0; e_va[k] = 1'b0; e_vb[k] = 1'b0; e_cnt[k] = 0;
      end
      e_wc = 1'b0;
      e_rh = 1'b0;
    end else begin
      same = (aa == ab);
      wra  = ea && (wa != 4'h0);
      wrb  = eb && (wb != 4'h0);
      e_wc = wra && wrb && same && ((wa & wb) != 4'h0);
      e_rh = ea && eb && same && (wra != wrb);
      for (int k = 0; k < NI; k++) begin
        if (ea && (!wra || wm_of(k) == 0)) begin
          dva[k][cyc + rl_of(k) - 1] = 1'b1;
          dda[k][cyc + rl_of(k) - 1] = mm[pidx_of(k)][aa];
        end
        if (eb && (!wrb || wm_of(k) == 0)) begin
          dvb[k][cyc + rl_of(k) - 1] = 1'b1;
          ddb[k][cyc + rl_of(k) - 1] = mm[pidx_of(k)][ab];
        end
        if (e_wc && e_cnt[k] < cmax_of(k)) e_cnt[k]++;
        e_va[k] = dva[k][cyc];
        e_vb[k] = dvb[k][cyc];
        if (e_va[k]) e_da[k] = dda[k][cyc];
        if (e_vb[k]) e_db[k] = ddb[k][cyc];
      end
      // Port A lands first; port B overwrites unless A owns a shared lane (flavour 0).
      for (int p = 0; p < 2; p++) begin
        for (int l = 0; l < 4; l++) begin
          if (ea && wa[l]) mm[p][aa][l*8 +: 8] = da[l*8 +: 8];
          if (eb && wb[l] && !(p == 0 && same && ea && wa[l])) mm[p][ab][l*8 +: 8] = db[l*8 +: 8];
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
  endtask

  initial begin
    for (int p = 0; p < 2; p++) for (int a = 0; a < 64; a++) mm[p][a] = '0;
    for (int k = 0; k < NI; k++) begin
      e_da[k] = '0; e_db[k] = '0; e_va[k] = 1'b0; e_vb[k] = 1'b0; e_cnt[k] = 0;
    end

    // Reset with traffic present.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 6'd7, 32'hFFFF_FFFF, 1'b1, 4'h0, 6'd7, 32'h0);

    // Known-zero contents.
    for (int a = 0; a < 32; a++) step(1'b1, 1'b1, 4'hF, 6'(a), 32'h0, 1'b1, 4'hF, 6'(a + 32), 32'h0);
    idle();

    // Single-lane write then cross-port read.
    step(1'b1, 1'b1, 4'b0010, 6'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 6'd0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd5, 32'h0);
    chk("t1 doutb_valid early", {31'b0, vb_g[2]}, 32'd0);
    idle();
    chk("t1 doutb_valid", {31'b0, vb_g[2]}, 32'd1);
    chk("t1 doutb", doutb_g[2], 32'h0000_CC00);

    // Overlapping write collision, then disjoint merge.
    step(1'b1, 1'b1, 4'b0011, 6'd9, 32'h1111_1111, 1'b1, 4'b0011, 6'd9, 32'h2222_2222);
    chk("t2 wr_collision", {31'b0, wc_g[2]}, 32'd1);
    chk("t2 coll_cnt", {16'b0, cnt_g[2]}, 32'd1);
    idle();
    chk("t2 wr_collision pulse", {31'b0, wc_g[2]}, 32'd0);
    step(1'b1, 1'b1, 4'h0, 6'd9, 32'h0, 1'b1, 4'h0, 6'd9, 32'h0);
    idle();
    chk("t2 prioA word", douta_g[2], 32'h0000_1111);
    chk("t2 prioB word", douta_g[8], 32'h0000_2222);
    step(1'b1, 1'b1, 4'b0001, 6'd9, 32'h1111_1111, 1'b1, 4'b0010, 6'd9, 32'h2222_2222);
    chk("t2 disjoint no flag", {31'b0, wc_g[2]}, 32'd0);
    step(1'b1, 1'b1, 4'h0, 6'd9, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    idle();
    chk("t2 merged prioA", douta_g[2], 32'h0000_2211);
    chk("t2 merged prioB", douta_g[8], 32'h0000_2211);

    // Read/write hazard across ports.
    step(1'b1, 1'b1, 4'hF, 6'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 6'd0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 6'd3, 32'h0, 1'b1, 4'hF, 6'd3, 32'h0);
    chk("t3 rw_hazard", {31'b0, rh_g[2]}, 32'd1);
    idle();
    chk("t3 read-first", douta_g[2], 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 4'h0, 6'd3, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    idle();
    chk("t3 new word", douta_g[2], 32'h0);

    // Reset mid-stream with a pending write.
    step(1'b1, 1'b1, 4'hF, 6'd20, 32'h1234_5678, 1'b0, 4'h0, 6'd0, 32'h0);
    step(1'b1, 1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd9, 32'h0);
    step(1'b1, 1'b1, 4'h0, 6'd5, 32'h0, 1'b1, 4'h0, 6'd9, 32'h0);
    step(1'b0, 1'b1, 4'hF, 6'd20, 32'hFFFF_FFFF, 1'b0, 4'h0, 6'd0, 32'h0);
    chk("t5 coll_cnt", {16'b0, cnt_g[2]}, 32'd0);
    for (int i = 0; i < 4; i++) idle();
    chk("t5 no late valid", {31'b0, va_g[7]}, 32'd0);
    step(1'b1, 1'b1, 4'h0, 6'd20, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    idle();
    chk("t5 write blocked", douta_g[2], 32'h1234_5678);

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'b1000, 6'd12, 32'(i), 1'b1, 4'b1000, 6'd12, 32'hFF);
    chk("t6 coll_cnt sat", {30'b0, cnt8}, 32'd3);
    chk("t6 coll_cnt wide", {16'b0, cnt_g[2]}, 32'd5);

    // Randomised mixed traffic on a small address window.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) != 0),
           1'($urandom_range(1)), ($urandom_range(1) != 0) ? 4'($urandom_range(15)) : 4'h0,
           6'($urandom_range(7)), $urandom,
           1'($urandom_range(1)), ($urandom_range(1) != 0) ? 4'($urandom_range(15)) : 4'h0,
           6'($urandom_range(7)), $urandom);
    end
    for (int i = 0; i < 5; i++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
